// File: rtl/disp_scheduler_pkg.sv
// Shared constants for the display scheduler: requester ids and active-low glyphs.
package disp_pkg;

    localparam int unsigned N_REQ = 4;

    typedef enum logic [1:0] {
        REQ_CLOCK = 2'd0,
        REQ_MODE  = 2'd1,
        REQ_DATE  = 2'd2,
        REQ_ALARM = 2'd3
    } req_id_t;

    // Bit 0 is segment a, bit 6 is segment g; a zero lights the segment.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'b1111110;

    localparam seg_t SEG_DIGIT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

endpackage

// File: rtl/disp_scheduler_if.sv
// Requester-side bundle of the display scheduler: requests, digit values, blink masks and the pins.
interface disp_scheduler_if;
    import disp_pkg::*;

    logic [N_REQ-1:0] req;
    logic [63:0]      val;
    logic [15:0]      blink_mask;
    logic [N_REQ-1:0] grant;
    seg_t             seg;
    logic [3:0]       digit;

    modport master (output req, val, blink_mask, input grant, seg, digit);
    modport slave  (input req, val, blink_mask, output grant, seg, digit);

endinterface

// File: rtl/disp_scheduler_bcd_to_seg.sv
// Combinational nibble to active-low seven-segment glyph: 0-9 digits, A-E dash, F blank.
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        if (nibble <= 4'd9)
            seg = SEG_DIGIT[nibble];
        else if (nibble == 4'hF)
            seg = SEG_BLANK;
    end

endmodule

// File: rtl/disp_scheduler.sv
// Fixed-priority owner arbitration with hold, digit scan and BCD decode for the shared display.
// Optional per-digit blinking is enabled by defining DISP_BLINK_EN.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned HOLD_STEPS = 500,
    parameter int unsigned BLINK_DIV  = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    disp_scheduler_if.slave   bus
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_STEPS + 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        idx;
    logic              step;
    logic [N_REQ-1:0]  grant, grant_next, top_req;
    logic [1:0]        owner;
    logic [3:0]        nibble;
    seg_t              glyph;
    seg_t              seg;
    logic [3:0]        digit;
    logic              blank;

    assign step = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        top_req = '0;
        owner   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req[i]) begin
                top_req    = '0;
                top_req[i] = 1'b1;
            end
            if (grant[i])
                owner = 2'(i);
        end
    end

    // One-hot compare: top_req > grant means a request above the current owner.
    always_comb begin
        grant_next = grant;
        if (grant == '0 || (bus.req & grant) == '0)
            grant_next = top_req;
        else if (top_req > grant && hold_cnt >= HOLD_W'(HOLD_STEPS))
            grant_next = top_req;
    end

    assign nibble = bus.val[{owner, idx, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef DISP_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank = phase & bus.blink_mask[{owner, idx}];
`else
    logic unused_mask;
    assign unused_mask = ^bus.blink_mask;
    assign blank       = 1'b0;
`endif

    // Pins only update on a scan step, so a new owner shows up at the next step boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= '0;
            hold_cnt <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            digit    <= '1;
        end else begin
            grant <= grant_next;
            if (grant_next != grant)
                hold_cnt <= '0;
            else if (step && hold_cnt < HOLD_W'(HOLD_STEPS))
                hold_cnt <= hold_cnt + 1'b1;

            if (step) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
                if (grant == '0) begin
                    digit <= '1;
                    seg   <= SEG_BLANK;
                end else begin
                    digit <= ~(4'b0001 << idx);
                    seg   <= blank ? SEG_BLANK : glyph;
                end
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign bus.grant = grant;
    assign bus.seg   = seg;
    assign bus.digit = digit;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed, table-driven bench for disp_scheduler with SCAN_DIV=4, HOLD_STEPS=3, BLINK_DIV=16.
module tb_disp_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

`ifdef DISP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    disp_scheduler_if bus ();

    disp_scheduler #(
        .SCAN_DIV   (4),
        .HOLD_STEPS (3),
        .BLINK_DIV  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the scan step lands on every edge where cyc % 4 == 0.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        vec_t t;
        t = vecs[n];
        return t.seg;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step();
        int budget;
        budget = 0;
        do begin
            tick();
            budget++;
        end while (cyc % 4 != 0 && budget < 10);
        if (cyc % 4 != 0) check("step_timeout", 32'(budget), 32'd4);
    endtask

    function automatic logic [3:0] exp_digit(input int c);
        logic [3:0] d;
        d = ~(4'b0001 << ((c / 4 - 1) % 4));
        return d;
    endfunction

    initial begin
        int g, s3, i, ph;
        logic [15:0] v16;
        logic [6:0] e;

        vecs = '{
            '{4'h0, 7'b0000001}, '{4'h1, 7'b1001111}, '{4'h2, 7'b0010010}, '{4'h3, 7'b0000110},
            '{4'h4, 7'b1001100}, '{4'h5, 7'b0100100}, '{4'h6, 7'b0100000}, '{4'h7, 7'b0001111},
            '{4'h8, 7'b0000000}, '{4'h9, 7'b0000100}, '{4'hA, 7'b1111110}, '{4'hB, 7'b1111110},
            '{4'hC, 7'b1111110}, '{4'hD, 7'b1111110}, '{4'hE, 7'b1111110}, '{4'hF, 7'b1111111}
        };

        bus.req = 4'hF;
        bus.val = '0;
        bus.blink_mask = '0;

        // Reset held with all requests asserted.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_seg",   32'(bus.seg),   32'h7F);
        check("rst_digit", 32'(bus.digit), 32'hF);
        reset = 1'b0;
        tick();
        check("post_rst_grant", 32'(bus.grant), 32'h8);

        // Owner 3 drops while req[1] rises; later req[0] must not preempt.
        bus.req = 4'b0010;
        tick();
        check("drop_switch", 32'(bus.grant), 32'h2);
        bus.req = 4'b0011;
        repeat (20) tick();
        check("no_low_preempt", 32'(bus.grant), 32'h2);

        // No requesters: grant clears and the display goes dark on the next step.
        bus.req = 4'b0000;
        tick();
        check("idle_grant", 32'(bus.grant), 32'h0);
        wait_step();
        check("idle_digit", 32'(bus.digit), 32'hF);
        check("idle_seg",   32'(bus.seg),   32'h7F);

        // Decode table: every nibble of requester 0 carries the same value.
        bus.req = 4'b0001;
        tick();
        check("own0_grant", 32'(bus.grant), 32'h1);
        for (int unsigned k = 0; k < 16; k++) begin
            bus.val = {48'h0, {4{vecs[k].nib}}};
            wait_step();
            check("dec_seg",   32'(bus.seg),   32'(vecs[k].seg));
            check("dec_digit", 32'(bus.digit), 32'(exp_digit(cyc)));
        end

        // Scan order over 1234: rightmost digit shows '4'.
        v16 = 16'h1234;
        bus.val = {48'h0, v16};
        for (int unsigned k = 0; k < 4; k++) begin
            wait_step();
            i = (cyc / 4 - 1) % 4;
            check("scan_digit", 32'(bus.digit), 32'(exp_digit(cyc)));
            check("scan_seg",   32'(bus.seg),   32'(glyph(v16[i*4 +: 4])));
        end

        // Hold: fresh owner 0, req[3] rises; switch one clk after the third step.
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0001;
        tick();
        check("hold_start", 32'(bus.grant), 32'h1);
        g  = cyc;
        s3 = (g / 4 + 1) * 4 + 8;
        bus.req = 4'b1001;
        for (int unsigned k = 0; k < 40 && cyc < s3; k++) tick();
        check("hold_keep", 32'(bus.grant), 32'h1);
        tick();
        check("hold_preempt", 32'(bus.grant), 32'h8);

        // Blink on digit 0 of requester 0.
        bus.req = 4'b0001;
        bus.blink_mask = 16'h0001;
        bus.val = {48'h0, v16};
        tick();
        check("blink_grant", 32'(bus.grant), 32'h1);
        for (int unsigned k = 0; k < 24; k++) begin
            wait_step();
            i  = (cyc / 4 - 1) % 4;
            ph = ((cyc - 1) / 16) % 2;
            e  = (BLINK_ON && i == 0 && ph == 1) ? 7'h7F : glyph(v16[i*4 +: 4]);
            check("blink_seg",   32'(bus.seg),   32'(e));
            check("blink_digit", 32'(bus.digit), 32'(exp_digit(cyc)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
